atm_txn_ctrl: RTL

Parametrised next-generation ATM transaction controller.
- Holds an account balance of configurable width and capacity.
- Validates deposit and withdraw requests against capacity, available funds and a per-session withdrawal limit.
- Breaks each accepted withdrawal into notes with a greedy state machine over the denominations 100, 50, 20, 10, 5 and 1, handing notes one at a time to a dispenser over a valid/ready handshake.
- Sits between the debounced button/switch front end and the BCD/7-segment display path; `balance` feeds the binary-to-BCD stage.

---
 rtl/atm_pkg.sv | 11 +
 rtl/atm_txn_ctrl_note_breakdown.sv | 51 +++++
 rtl/atm_txn_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared denominations, error codes and FSM encoding for the ATM controller
package atm_pkg;
  localparam int NUM_DEN = 6;
  // Index 0 is the largest note so the greedy walk runs from DEN[0] upward.
  localparam logic [NUM_DEN-1:0][6:0] DEN = {7'd1, 7'd5, 7'd10, 7'd20, 7'd50, 7'd100};
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OVF   = 2'd1;
  localparam logic [1:0] ERR_FUNDS = 2'd2;
  localparam logic [1:0] ERR_LIMIT = 2'd3;
  typedef enum logic [1:0] {IDLE, DISPENSE, FINISH} state_e;
endpackage

// File: rtl/atm_txn_ctrl_note_breakdown.sv
// note_breakdown: greedy note-by-note dispenser over a valid/ready handshake
module note_breakdown
  import atm_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             note_ready,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic             finish
);
  logic             active_q, active_d;
  logic [AMT_W-1:0] rem_q, rem_d, den;
  logic [2:0]       idx_q, idx_d;
  assign den        = AMT_W'(DEN[idx_q]);
  assign note_valid = active_q && rem_q >= den;
  assign note_idx   = idx_q;
  // Finish on the transfer that empties remaining, so the caller sees done next cycle.
  assign finish     = note_valid && note_ready && rem_q == den;
  always_comb begin
    active_d = active_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    if (start) begin
      active_d = 1'b1;
      rem_d    = amount;
      idx_d    = '0;
    end else if (active_q) begin
      if (!note_valid) idx_d = idx_q + 3'd1;
      else if (note_ready) begin
        rem_d    = rem_q - den;
        active_d = !finish;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (res) begin
      active_q <= 1'b0;
      rem_q    <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
    end
  end
endmodule

// File: rtl/atm_txn_ctrl.sv
// atm_txn_ctrl: balance/session bookkeeping, request validation and transaction FSM
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int BAL_W    = 10,
  parameter int AMT_W    = 8,
  parameter int MAX_BAL  = 999,
  parameter int WD_LIMIT = 500
) (
  input  logic             clk,
  input  logic             res,
  input  logic             dep_pulse,
  input  logic             with_pulse,
  input  logic             session_clr,
  input  logic [AMT_W-1:0] amount,
  input  logic             note_ready,
  output logic             note_valid,
  output logic [2:0]       note_idx,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] session_wd,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             max_bal,
  output logic             min_bal
);
  localparam int SW = (BAL_W > AMT_W ? BAL_W : AMT_W) + 1;
  state_e           state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d, swd_q, swd_d, swd_eff;
  logic [1:0]       err_q, err_d;
  logic             done_q, done_d, start, finish, req;
  logic [SW-1:0]    dep_sum, wd_sum, amt_x;
  // A clear coinciding with a withdraw applies before the limit check.
  assign swd_eff = session_clr ? '0 : swd_q;
  assign amt_x   = SW'(amount);
  assign dep_sum = SW'(bal_q) + amt_x;
  assign wd_sum  = SW'(swd_eff) + amt_x;
  assign req     = (dep_pulse ^ with_pulse) && amount != '0;
  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    swd_d   = swd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    start   = 1'b0;
    if (state_q == IDLE) begin
      swd_d = swd_eff;
      if (req && dep_pulse) begin
        if (dep_sum > SW'(MAX_BAL)) err_d = ERR_OVF;
        else begin
          bal_d  = dep_sum[BAL_W-1:0];
          err_d  = ERR_NONE;
          done_d = 1'b1;
        end
      end else if (req) begin
        if (amt_x > SW'(bal_q)) err_d = ERR_FUNDS;
        else if (wd_sum > SW'(WD_LIMIT)) err_d = ERR_LIMIT;
        else begin
          bal_d   = bal_q - BAL_W'(amount);
          swd_d   = wd_sum[BAL_W-1:0];
          err_d   = ERR_NONE;
          start   = 1'b1;
          state_d = DISPENSE;
        end
      end
    end else if (state_q == DISPENSE) state_d = finish ? FINISH : DISPENSE;
    else state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      bal_q   <= '0;
      swd_q   <= '0;
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      swd_q   <= swd_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
  note_breakdown #(.AMT_W(AMT_W)) u_nb (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .amount     (amount),
    .note_ready (note_ready),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .finish     (finish)
  );
  assign balance    = bal_q;
  assign session_wd = swd_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q || state_q == FINISH;
  assign err        = err_q;
  assign max_bal    = bal_q == BAL_W'(MAX_BAL);
  assign min_bal    = bal_q == '0;
endmodule
